// File: rtl/gesture_pkg.sv
// gesture_pkg -- shared types and constants for the gesture event scheduler.
//   state_e        : scheduler FSM states (IDLE / ACTIVE / GAP)
//   code_t         : 2-bit gesture event code, bit index of the gesture bus
//   flags_t        : beep / segment indicator pair driven for one event
//   code_to_flags  : event code -> one-hot indicator decode
//   bit_count4     : number of set bits in a 4-bit vector
//   bit_index4     : index of the set bit in a one-hot 4-bit vector
package gesture_pkg;

    localparam int CODE_W = 2;

    typedef logic [CODE_W-1:0] code_t;

    localparam code_t GEST_UP    = 2'd0;
    localparam code_t GEST_DOWN  = 2'd1;
    localparam code_t GEST_LEFT  = 2'd2;
    localparam code_t GEST_RIGHT = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2
    } state_e;

    typedef struct packed {
        logic [1:0] seg;
        logic [1:0] beep;
    } flags_t;

    // Codes 0/1 drive the beeper, codes 2/3 drive the segment display.
    function automatic flags_t code_to_flags(input code_t code);
        flags_t f;
        f = '0;
        case (code)
            GEST_UP:   f.beep = 2'b01;
            GEST_DOWN: f.beep = 2'b10;
            GEST_LEFT: f.seg  = 2'b01;
            default:   f.seg  = 2'b10;
        endcase
        return f;
    endfunction

    function automatic logic [2:0] bit_count4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

    // Only meaningful when exactly one bit is set.
    function automatic code_t bit_index4(input logic [3:0] v);
        code_t idx;
        idx = '0;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) begin
                idx = code_t'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/gesture_evt_sched_if.sv
// gesture_evt_sched_if -- signal bundle between the gesture front end / indicator
// drivers and the event scheduler.
//   gest_data [7:0] : level-coded gesture bus, only [3:0] used
//   flush           : synchronous queue flush / event abort
//   beep_flag [1:0] : one-hot beep request
//   seg_flag  [1:0] : one-hot segment request
//   busy            : scheduler playing or holding queued events
//   drop            : one-cycle pulse when a gesture edge is discarded
//   evt_cnt   [7:0] : events started, wrapping
// modport master : the side that drives gestures and watches the indicators
// modport slave  : the scheduler itself
interface gesture_evt_sched_if;

    logic [7:0] gest_data;
    logic       flush;
    logic [1:0] beep_flag;
    logic [1:0] seg_flag;
    logic       busy;
    logic       drop;
    logic [7:0] evt_cnt;

    modport master (
        output gest_data,
        output flush,
        input  beep_flag,
        input  seg_flag,
        input  busy,
        input  drop,
        input  evt_cnt
    );

    modport slave (
        input  gest_data,
        input  flush,
        output beep_flag,
        output seg_flag,
        output busy,
        output drop,
        output evt_cnt
    );

endinterface

// File: rtl/gest_evt_fifo.sv
// gest_evt_fifo -- small synchronous FIFO of gesture event codes.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous empty (pointers and count to zero), wins over push/pop
//   push, din  : write request and code; ignored when full unless a pop happens too
//   pop        : read request; ignored when empty
//   dout       : show-ahead head of queue (valid whenever !empty)
//   full/empty : derived from the registered occupancy count
module gest_evt_fifo
    import gesture_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  clear,
    input  logic  push,
    input  logic  pop,
    input  code_t din,
    output code_t dout,
    output logic  full,
    output logic  empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    code_t         mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop, wr_en;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_FULL);
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path can
        // leave one unassigned and infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        wr_en    = 1'b0;
        do_pop   = pop && !empty;
        // A full queue still accepts a push when the head leaves the same cycle.
        do_push  = push && (!full || do_pop);

        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; the count guarantees no entry is
    // read before it has been written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/gesture_evt_sched.sv
// gesture_evt_sched -- queues single-gesture rising edges from the PAJ7620 gesture
// bus and plays them out one at a time on the beep / segment indicators: each
// event holds its flag for HOLD_CYC cycles, then GAP_CYC quiet cycles follow.
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   bus (slave)        : gest_data/flush in; beep_flag/seg_flag/busy/drop/evt_cnt out
// Parameters: HOLD_CYC >= 1, GAP_CYC >= 1, FIFO_DEPTH power of two >= 2.
module gesture_evt_sched
    import gesture_pkg::*;
#(
    parameter int unsigned HOLD_CYC   = 25_000_000,
    parameter int unsigned GAP_CYC    = 5_000_000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    gesture_evt_sched_if.slave  bus
);

    localparam logic [31:0] HOLD_LOAD = 32'(HOLD_CYC - 1);
    localparam logic [31:0] GAP_LOAD  = 32'(GAP_CYC - 1);

    // Edge detect
    logic [3:0] gest_q, gest_d;
    logic [3:0] pedge;
    logic [2:0] edge_bits;
    code_t      push_code;
    logic       push;
    logic       drop_q, drop_d;

    // Queue
    logic  fifo_full, fifo_empty;
    code_t fifo_dout;
    logic  pop;

    // Scheduler
    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    flags_t      flags_q, flags_d;
    logic [7:0]  evt_cnt_q, evt_cnt_d;

    // The upper nibble of the gesture bus carries nothing for this block.
    logic unused_gest_hi;
    assign unused_gest_hi = ^bus.gest_data[7:4];

    always_comb begin
        gest_d    = bus.gest_data[3:0];
        pedge     = bus.gest_data[3:0] & ~gest_q;
        edge_bits = bit_count4(pedge);
        push_code = bit_index4(pedge);
        push      = (edge_bits == 3'd1) && !bus.flush;
        // Flush swallows any edge silently; otherwise an ambiguous multi-bit edge
        // or a push into a full queue with no simultaneous pop is reported.
        drop_d    = !bus.flush &&
                    ((edge_bits > 3'd1) || (push && fifo_full && !pop));
    end

    gest_evt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .clear (bus.flush),
        .push  (push),
        .pop   (pop),
        .din   (push_code),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // FSM state register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (!fifo_empty)    state_d = ACTIVE;
                ACTIVE:  if (cnt_q == '0)    state_d = GAP;
                GAP:     if (cnt_q == '0)    state_d = IDLE;
                default:                     state_d = IDLE;
            endcase
        end
    end

    // FSM outputs and datapath. The pop decision looks only at the registered
    // FIFO count, so a code pushed this cycle is played no earlier than the next.
    always_comb begin
        pop       = 1'b0;
        cnt_d     = cnt_q;
        flags_d   = flags_q;
        evt_cnt_d = evt_cnt_q;
        if (bus.flush) begin
            cnt_d   = '0;
            flags_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        flags_d   = code_to_flags(fifo_dout);
                        cnt_d     = HOLD_LOAD;
                        evt_cnt_d = evt_cnt_q + 8'd1;
                    end
                end
                ACTIVE: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 32'd1;
                    end else begin
                        flags_d = '0;
                        cnt_d   = GAP_LOAD;
                    end
                end
                GAP: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 32'd1;
                    end
                end
                default: begin
                    cnt_d   = '0;
                    flags_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            gest_q    <= '0;
            drop_q    <= 1'b0;
            cnt_q     <= '0;
            flags_q   <= '0;
            evt_cnt_q <= '0;
        end else begin
            gest_q    <= gest_d;
            drop_q    <= drop_d;
            cnt_q     <= cnt_d;
            flags_q   <= flags_d;
            evt_cnt_q <= evt_cnt_d;
        end
    end

    assign bus.beep_flag = flags_q.beep;
    assign bus.seg_flag  = flags_q.seg;
    assign bus.drop      = drop_q;
    assign bus.evt_cnt   = evt_cnt_q;
    assign bus.busy      = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_gesture_evt_sched.sv
// tb_gesture_evt_sched -- directed self-checking bench for gesture_evt_sched with
// HOLD_CYC=4, GAP_CYC=2, FIFO_DEPTH=4. Expected event codes are queued when a
// gesture edge is driven and popped as each indicator flag rises.
module tb_gesture_evt_sched;

    localparam int HOLD    = 4;
    localparam int GAP     = 2;
    localparam int DEPTH   = 4;
    localparam int SPACING = HOLD + GAP + 1;

    logic sys_clk = 1'b0;
    logic sys_rst_n;

    gesture_evt_sched_if bus ();

    gesture_evt_sched #(
        .HOLD_CYC   (HOLD),
        .GAP_CYC    (GAP),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int unsigned cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int drop_seen = 0;
    always @(negedge sys_clk) if (bus.drop === 1'b1) drop_seen <= drop_seen + 1;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [1:0]  sb [$];
    logic [7:0]  exp_evt;
    int unsigned first_rise;
    int unsigned last_rise;
    int unsigned drv_cyc;
    int          d0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] flags_now();
        return {bus.seg_flag, bus.beep_flag};
    endfunction

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    // Wait for n events; each must match the scoreboard head, last HOLD cycles,
    // and (within one call) rise SPACING cycles after the previous one.
    task automatic expect_events(input int n);
        logic [3:0] exp_fl;
        logic [1:0] code;
        int         waited;
        int         hold;
        for (int i = 0; i < n; i++) begin
            waited = 0;
            @(negedge sys_clk);
            while (flags_now() === 4'b0000 && waited < 60) begin
                @(negedge sys_clk);
                waited++;
            end
            if (flags_now() === 4'b0000) begin
                check("rise_seen", 32'(flags_now() != 4'b0000), 32'd1);
                return;
            end
            if (sb.size() == 0) begin
                check("unexpected_event", 32'(flags_now()), 32'd0);
                return;
            end
            code   = sb.pop_front();
            exp_fl = 4'b0001 << code;
            exp_evt++;
            if (i == 0) first_rise = cyc;
            else        check("spacing", cyc - last_rise, SPACING);
            last_rise = cyc;
            check("flags", 32'(flags_now()), 32'(exp_fl));
            check("evt_cnt", 32'(bus.evt_cnt), 32'(exp_evt));
            hold = 1;
            @(negedge sys_clk);
            while (flags_now() === exp_fl && hold < 40) begin
                hold++;
                @(negedge sys_clk);
            end
            check("hold", hold, HOLD);
            check("flags_after_hold", 32'(flags_now()), 32'd0);
        end
    endtask

    initial begin
        sys_rst_n     = 1'b0;
        bus.gest_data = 8'h00;
        bus.flush     = 1'b0;
        exp_evt       = 8'd0;

        // Reset state
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        check("rst_beep", 32'(bus.beep_flag), 32'd0);
        check("rst_seg", 32'(bus.seg_flag), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_drop", 32'(bus.drop), 32'd0);
        check("rst_evt_cnt", 32'(bus.evt_cnt), 32'd0);
        #1 sys_rst_n = 1'b1;
        step();
        step();
        check("idle_busy", 32'(bus.busy), 32'd0);

        // Single event with 2-cycle latency, then busy clears after the gap
        bus.gest_data = 8'h01;
        drv_cyc = cyc;
        sb.push_back(2'd0);
        expect_events(1);
        check("single_latency", first_rise - drv_cyc, 32'd2);
        check("single_busy_gap1", 32'(bus.busy), 32'd1);
        @(negedge sys_clk);
        check("single_busy_gap2", 32'(bus.busy), 32'd1);
        @(negedge sys_clk);
        check("single_busy_idle", 32'(bus.busy), 32'd0);

        // Burst: edges on bits 2, 0, 3 on consecutive cycles; upper nibble noise
        step();
        bus.gest_data = 8'h00;
        step();
        step();
        d0 = drop_seen;
        bus.gest_data = 8'hF4; sb.push_back(2'd2);
        step();
        bus.gest_data = 8'h05; sb.push_back(2'd0);
        step();
        bus.gest_data = 8'hAD; sb.push_back(2'd3);
        expect_events(3);
        @(negedge sys_clk);
        @(negedge sys_clk);
        check("burst_busy_end", 32'(bus.busy), 32'd0);
        check("burst_no_drop", drop_seen - d0, 32'd0);

        // Overflow: 6 edges, 1 popped + 4 queued, 6th dropped
        step();
        bus.gest_data = 8'h00;
        step();
        step();
        d0 = drop_seen;
        fork
            begin
                step(); bus.gest_data = 8'h01; sb.push_back(2'd0);
                step(); bus.gest_data = 8'h03; sb.push_back(2'd1);
                step(); bus.gest_data = 8'h07; sb.push_back(2'd2);
                step(); bus.gest_data = 8'h0F; sb.push_back(2'd3);
                step(); bus.gest_data = 8'h0E;
                step(); bus.gest_data = 8'h0F; sb.push_back(2'd0);
                step(); bus.gest_data = 8'h0E;
                step(); bus.gest_data = 8'h0F;
                step(); check("ovf_drop", 32'(bus.drop), 32'd1);
                step(); check("ovf_drop_clear", 32'(bus.drop), 32'd0);
            end
            expect_events(5);
        join
        @(negedge sys_clk);
        @(negedge sys_clk);
        check("ovf_busy_end", 32'(bus.busy), 32'd0);
        check("ovf_drop_count", drop_seen - d0, 32'd1);
        check("ovf_evt_cnt", 32'(bus.evt_cnt), 32'd9);

        // Multi-bit edge: drop once, nothing queued
        step();
        bus.gest_data = 8'h00;
        step();
        step();
        d0 = drop_seen;
        bus.gest_data = 8'h03;
        step();
        check("multi_drop", 32'(bus.drop), 32'd1);
        step();
        check("multi_drop_clear", 32'(bus.drop), 32'd0);
        repeat (3) step();
        check("multi_flags", 32'(flags_now()), 32'd0);
        check("multi_busy", 32'(bus.busy), 32'd0);
        check("multi_evt_cnt", 32'(bus.evt_cnt), 32'(exp_evt));
        check("multi_drop_count", drop_seen - d0, 32'd1);

        // Flush during ACTIVE cycle 2 with two events queued
        bus.gest_data = 8'h00;
        step();
        step();
        bus.gest_data = 8'h01; sb.push_back(2'd0);
        step();
        bus.gest_data = 8'h03;
        step();
        bus.gest_data = 8'h07;
        exp_evt++;
        check("flush_pre_flags", 32'(flags_now()), 32'(4'b0001 << sb.pop_front()));
        check("flush_pre_evt_cnt", 32'(bus.evt_cnt), 32'(exp_evt));
        step();
        bus.flush = 1'b1;
        check("flush_pre_busy", 32'(bus.busy), 32'd1);
        step();
        bus.flush = 1'b0;
        check("flush_flags", 32'(flags_now()), 32'd0);
        check("flush_busy", 32'(bus.busy), 32'd0);
        check("flush_evt_cnt", 32'(bus.evt_cnt), 32'(exp_evt));
        repeat (10) step();
        check("flush_flags_later", 32'(flags_now()), 32'd0);
        check("flush_busy_later", 32'(bus.busy), 32'd0);
        check("flush_evt_cnt_later", 32'(bus.evt_cnt), 32'(exp_evt));

        // Asynchronous reset during GAP
        bus.gest_data = 8'h00;
        step();
        step();
        bus.gest_data = 8'h01; sb.push_back(2'd0);
        expect_events(1);
        #2 sys_rst_n = 1'b0;
        #1;
        check("arst_beep", 32'(bus.beep_flag), 32'd0);
        check("arst_seg", 32'(bus.seg_flag), 32'd0);
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_drop", 32'(bus.drop), 32'd0);
        check("arst_evt_cnt", 32'(bus.evt_cnt), 32'd0);
        exp_evt = 8'd0;
        // Level still high at release counts as an edge on the first clock.
        #1 sys_rst_n = 1'b1;
        sb.push_back(2'd0);
        expect_events(1);

        // 255 more events: 256 since reset, counter wraps to 0
        for (int i = 1; i < 256; i++) begin
            step();
            bus.gest_data = 8'h00;
            step();
            bus.gest_data = 8'(1 << (i % 4));
            sb.push_back(2'(i % 4));
            expect_events(1);
        end
        @(negedge sys_clk);
        @(negedge sys_clk);
        check("wrap_busy", 32'(bus.busy), 32'd0);
        check("wrap_evt_cnt", 32'(bus.evt_cnt), 32'd0);
        check("sb_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
